// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner: shadowed BCD digits, a guard
// interval at the start of every digit slot, leading-zero blanking and an "E" glyph.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int              IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   GUARD_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]   IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;

  // Active-low {a..g}; anything that is not BCD shows "E".
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    case (code)
      4'd0:    bcd_to_seg = 7'b0000001;
      4'd1:    bcd_to_seg = 7'b1001111;
      4'd2:    bcd_to_seg = 7'b0010010;
      4'd3:    bcd_to_seg = 7'b0000110;
      4'd4:    bcd_to_seg = 7'b1001100;
      4'd5:    bcd_to_seg = 7'b0100100;
      4'd6:    bcd_to_seg = 7'b0100000;
      4'd7:    bcd_to_seg = 7'b0001111;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0000100;
      default: bcd_to_seg = 7'b0110000;
    endcase
  endfunction

  logic [CW-1:0]             cnt_r;
  logic [IW-1:0]             idx_r;
  logic                      wrap_pend_r;
  logic [4*NUM_DIGITS-1:0]   sh_digits_r;
  logic [NUM_DIGITS-1:0]     sh_dp_r;
  logic [6:0]                glyph_seg_r;
  logic                      glyph_dp_r;
  logic [6:0]                seg_r;
  logic                      dp_n_r;
  logic [NUM_DIGITS-1:0]     an_r;
  logic                      frame_done_r;

  logic                      cnt_wrap_s;
  logic [NUM_DIGITS-1:0]     lz_mask_s;
  logic [3:0]                cur_code_s;
  logic [6:0]                next_seg_s;
  logic                      next_dp_s;

  assign cnt_wrap_s = (cnt_r == CNT_MAX);

  // Leading-zero mask: a digit blanks when it and everything above it is zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask_s  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above   = zero_above & (sh_digits_r[4*k +: 4] == 4'd0);
      lz_mask_s[k] = zero_above & LZ_BLANK;
    end
    lz_mask_s[0] = 1'b0;
  end

  // Glyph for the digit under the scan index, from shadow values.
  always_comb begin
    cur_code_s = sh_digits_r[{idx_r, 2'b00} +: 4];
    if (lz_mask_s[idx_r]) begin
      next_seg_s = SEG_BLANK;
    end else begin
      next_seg_s = bcd_to_seg(cur_code_s);
    end
    next_dp_s = ~sh_dp_r[idx_r];
  end

  // Prescaler, scan index and end-of-frame marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= '0;
      idx_r       <= '0;
      wrap_pend_r <= 1'b0;
    end else begin
      wrap_pend_r <= cnt_wrap_s && (idx_r == IDX_MAX);
      if (cnt_wrap_s) begin
        cnt_r <= '0;
        idx_r <= (idx_r == IDX_MAX) ? '0 : idx_r + 1'b1;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  // Shadow register; reset wins over a coincident load.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_digits_r <= '0;
      sh_dp_r     <= '0;
    end else if (load) begin
      sh_digits_r <= digits;
      sh_dp_r     <= dp_in;
    end
  end

  // Slot latch: the lit digit is frozen for the whole slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_seg_r <= SEG_BLANK;
      glyph_dp_r  <= 1'b1;
    end else if (cnt_r == '0) begin
      glyph_seg_r <= next_seg_s;
      glyph_dp_r  <= next_dp_s;
    end
  end

  // Registered pins; the slot's first cycle is always in the guard, so the
  // glyph latched on that cycle is ready before anything is shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r        <= SEG_BLANK;
      dp_n_r       <= 1'b1;
      an_r         <= '1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_pend_r;
      an_r         <= '1;
      if (cnt_r < GUARD_END) begin
        seg_r  <= SEG_BLANK;
        dp_n_r <= 1'b1;
      end else begin
        seg_r  <= glyph_seg_r;
        dp_n_r <= glyph_dp_r;
        if (digit_en[idx_r]) begin
          an_r[idx_r] <= 1'b0;
        end
      end
    end
  end

  assign seg        = seg_r;
  assign dp_n       = dp_n_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule
